imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
Responder end of the instruction-fetch path. It accepts fetch addresses (the PC value) over a valid/ready request channel and reads the instruction word from a synchronous-read instruction SRAM. Each instruction is returned in request order over a valid/ready response channel, through a small response FIFO that absorbs backpressure. It also handles misaligned and out-of-range fetches, and a flush on branch redirect.

Parameters:
ADDR_WIDTH, 32 (from my_pkg), byte address width
DATA_WIDTH, 32, instruction width
IMEM_DEPTH_LOG2, 12, log2 of SRAM depth in words
FIFO_DEPTH, 3, response FIFO entries; min 2; >=3 sustains 1 fetch/cycle

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  discard all fetches accepted before this cycle
req_valid  input  1  fetch request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_addr  input  ADDR_WIDTH  byte fetch address
mem_en  output  1  SRAM read enable
mem_addr  output  IMEM_DEPTH_LOG2  SRAM word index = req_addr[IMEM_DEPTH_LOG2+1:2]
mem_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after mem_en
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts when rsp_valid && rsp_ready
rsp_inst  output  DATA_WIDTH  instruction word
rsp_addr  output  ADDR_WIDTH  fetch address of this instruction
rsp_err  output  1  misaligned or out-of-range fetch

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high:
  - rsp_valid=0, req_ready=0, mem_en=0.
  - rsp_inst, rsp_addr and rsp_err read 0.
  - FIFO empty; in-flight stage empty.
- Reset mid-operation drops every pending fetch. No response is produced for it.
- Occupancy: occ = fifo_count + inflight_valid, where inflight is a one-entry stage covering the SRAM read cycle.
- req_ready = !rst && (flush || occ < FIFO_DEPTH). rsp_ready never combinationally affects req_ready.
- Accept in cycle N:
  - Error check: err = (req_addr[1:0]!=0) || (req_addr[ADDR_WIDTH-1:IMEM_DEPTH_LOG2+2]!=0).
  - mem_en = accept && !err, driven combinationally in cycle N.
  - Inflight captures {addr, err} at the end of N.
- Cycle N+1:
  - FIFO push of {inst, addr, err}.
  - inst = mem_rdata if !err; otherwise INST_NOP (32'h0000_0013).
- Cycle N+2: entry is at the FIFO head and rsp_valid=1 at the earliest. Latency is 2 cycles.
- Response channel:
  - The FIFO head drives rsp_inst, rsp_addr and rsp_err.
  - Once rsp_valid is asserted, the head stays stable until it is popped.
- Ordering: responses leave strictly in acceptance order. Error responses follow the same path and latency.
- Simultaneous push and pop in one cycle is allowed, including when the FIFO is full. Overflow cannot occur because of the occ gating.
- Flush in cycle F:
  - The FIFO is emptied and any inflight entry is invalidated at the end of F.
  - rsp_valid=0 from F+1.
  - Any pop in cycle F still completes.
  - A request accepted in cycle F survives and is the first response after the flush.
- Empty FIFO: rsp_valid=0; rsp_* hold the last head value (no requirement on it).
- Out-of-range addresses never assert mem_en, so the SRAM is never accessed for them.
- Counters and FIFO pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH need not be a power of 2.

Decomposition:
- my_pkg gains:
  - IMEM_DEPTH_LOG2.
  - INST_NOP.
  - typedef imem_rsp_t, a packed struct {inst, addr, err}.
- One sub-module, imem_rsp_fifo: a synchronous FIFO of imem_rsp_t with push, pop, clear, count, full and empty, and async active-high reset.
- Error check, the inflight stage and the occ/ready logic stay in imem_fetch_responder.

Test Plan:
- Back-to-back fetches at 0x0, 0x4, 0x8 with rsp_ready=1 and the SRAM preloaded (word0=0x00500093) -> accepted in cycles 0,1,2. Responses in cycles 2,3,4, in order; the first is rsp_inst=0x00500093, rsp_addr=0x0. req_ready stays 1 throughout.
- rsp_ready=0 while requests are streamed -> exactly 3 accepts, then req_ready=0. After rsp_ready=1, the 3 responses drain in order and req_ready returns the cycle after the first pop.
- req_addr=0x6 -> mem_en=0, response rsp_err=1, rsp_inst=0x00000013, rsp_addr=0x6. req_addr=0x4000 (out of range for depth 4096) -> same result with rsp_addr=0x4000.
- Fetch 0x0 and 0x4 accepted, flush in the cycle 0x100 is accepted -> only 0x100 is returned; rsp_valid=0 the cycle after the flush.
- rst pulsed asynchronously between clock edges while 2 responses are pending -> rsp_valid, req_ready and mem_en drop immediately. After release no stale response appears, and a new fetch at 0x8 returns after 2 cycles.

Source files
------------

// File: rtl/my_pkg.sv
// Shared widths, constants and the response record for the instruction-fetch path.
package my_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int IMEM_DEPTH_LOG2 = 12;

    // ADDI x0, x0, 0: returned in place of SRAM data for faulting fetches.
    localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO; depth need not be a power of two.
// Clear wins over push and pop; push into a full FIFO is legal only with a pop.
module imem_rsp_fifo
    import my_pkg::*;
#(
    parameter int DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  imem_rsp_t        i_data,
    output imem_rsp_t        o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    imem_rsp_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage: entries cleared on reset so the head reads zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and count, wrapping at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: request channel -> sync SRAM read -> response FIFO.
// A one-entry in-flight stage covers the SRAM read cycle; the FIFO absorbs
// response backpressure. Fixed 2-cycle accept-to-response latency.
module imem_fetch_responder
    import my_pkg::*;
#(
    parameter int FIFO_DEPTH = 3,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    output logic                       mem_en,
    output logic [IMEM_DEPTH_LOG2-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_inst,
    output logic [ADDR_WIDTH-1:0]      rsp_addr,
    output logic                       rsp_err
);

    logic                  r_inf_valid;
    logic [ADDR_WIDTH-1:0] r_inf_addr;
    logic                  r_inf_err;

    logic                  w_err;
    logic                  w_accept;
    logic                  w_room;
    logic [CNT_W:0]        w_occ;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    imem_rsp_t             w_push_data;
    imem_rsp_t             w_head;

    // Misaligned, or beyond the last SRAM word.
    assign w_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr[ADDR_WIDTH-1:IMEM_DEPTH_LOG2+2] != '0);

    // Occupancy counts the in-flight read so a full FIFO can never overflow.
    // Full implies occ >= depth; the explicit guard keeps the intent obvious.
    assign w_occ     = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inf_valid};
    assign w_room    = !w_fifo_full && (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign req_ready = !rst && (flush || w_room);
    assign w_accept  = req_valid && req_ready;

    assign mem_en   = w_accept && !w_err;
    assign mem_addr = req_addr[IMEM_DEPTH_LOG2+1:2];

    // In-flight stage: a request accepted during flush survives into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inf_valid <= 1'b0;
            r_inf_addr  <= '0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_accept;
            if (w_accept) begin
                r_inf_addr <= req_addr;
                r_inf_err  <= w_err;
            end
        end
    end

    // Faulting fetches never read the SRAM, so they carry a NOP instead.
    always_comb begin
        w_push_data      = '0;
        w_push_data.inst = r_inf_err ? INST_NOP : mem_rdata;
        w_push_data.addr = r_inf_addr;
        w_push_data.err  = r_inf_err;
    end

    assign w_push = r_inf_valid && !flush;
    assign w_pop  = rsp_valid && rsp_ready;

    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rsp_valid = !w_fifo_empty;
    assign rsp_inst  = w_head.inst;
    assign rsp_addr  = w_head.addr;
    assign rsp_err   = w_head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for the instruction-fetch responder with a behavioural SRAM.
module tb_imem_fetch_responder;
    import my_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       flush = 1'b0;
    logic                       req_valid = 1'b0;
    logic                       req_ready;
    logic [ADDR_WIDTH-1:0]      req_addr = '0;
    logic                       mem_en;
    logic [IMEM_DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]      mem_rdata = '0;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b0;
    logic [DATA_WIDTH-1:0]      rsp_inst;
    logic [ADDR_WIDTH-1:0]      rsp_addr;
    logic                       rsp_err;

    int checks = 0;
    int failures = 0;

    imem_fetch_responder #(.FIFO_DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // SRAM contents: word 0 is preloaded, other words encode their index.
    function automatic logic [31:0] sram_word(input logic [IMEM_DEPTH_LOG2-1:0] idx);
        if (idx == '0) return 32'h0050_0093;
        return 32'hC0DE_0000 | {20'h0, idx};
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= sram_word(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs checked 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        #1 rst = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        settle();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mem_en",    64'(mem_en),    64'd0);
        check("rst_rsp_inst",  64'(rsp_inst),  64'd0);
        check("rst_rsp_addr",  64'(rsp_addr),  64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // ---------------- back-to-back fetches ----------------
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0; settle();
        check("b2b_c0_ready",    64'(req_ready), 64'd1);
        check("b2b_c0_mem_en",   64'(mem_en),    64'd1);
        check("b2b_c0_mem_addr", 64'(mem_addr),  64'd0);
        check("b2b_c0_valid",    64'(rsp_valid), 64'd0);
        step();
        req_addr = 32'h4; settle();
        check("b2b_c1_ready",    64'(req_ready), 64'd1);
        check("b2b_c1_mem_addr", 64'(mem_addr),  64'd1);
        check("b2b_c1_valid",    64'(rsp_valid), 64'd0);
        step();
        req_addr = 32'h8; settle();
        check("b2b_c2_ready", 64'(req_ready), 64'd1);
        check("b2b_c2_valid", 64'(rsp_valid), 64'd1);
        check("b2b_c2_inst",  64'(rsp_inst),  64'h0050_0093);
        check("b2b_c2_addr",  64'(rsp_addr),  64'h0);
        check("b2b_c2_err",   64'(rsp_err),   64'd0);
        step();
        req_valid = 1'b0; settle();
        check("b2b_c3_valid", 64'(rsp_valid), 64'd1);
        check("b2b_c3_inst",  64'(rsp_inst),  64'hC0DE_0001);
        check("b2b_c3_addr",  64'(rsp_addr),  64'h4);
        step();
        check("b2b_c4_valid", 64'(rsp_valid), 64'd1);
        check("b2b_c4_inst",  64'(rsp_inst),  64'hC0DE_0002);
        check("b2b_c4_addr",  64'(rsp_addr),  64'h8);
        step();
        check("b2b_c5_valid", 64'(rsp_valid), 64'd0);

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h10; settle();
        check("bp_c0_ready", 64'(req_ready), 64'd1);
        step();
        req_addr = 32'h14; settle();
        check("bp_c1_ready", 64'(req_ready), 64'd1);
        step();
        req_addr = 32'h18; settle();
        check("bp_c2_ready", 64'(req_ready), 64'd1);
        step();
        req_addr = 32'h1C; settle();
        check("bp_c3_ready",  64'(req_ready), 64'd0);
        check("bp_c3_mem_en", 64'(mem_en),    64'd0);
        check("bp_c3_head",   64'(rsp_addr),  64'h10);
        step();
        check("bp_c4_ready", 64'(req_ready), 64'd0);
        step();
        rsp_ready = 1'b1; settle();
        check("bp_c5_ready_pop_cycle", 64'(req_ready), 64'd0);
        check("bp_c5_head",  64'(rsp_addr),  64'h10);
        check("bp_c5_inst",  64'(rsp_inst),  64'hC0DE_0004);
        step();
        check("bp_c6_ready", 64'(req_ready), 64'd1);
        check("bp_c6_head",  64'(rsp_addr),  64'h14);
        step();
        req_valid = 1'b0; settle();
        check("bp_c7_head",  64'(rsp_addr),  64'h18);
        check("bp_c7_inst",  64'(rsp_inst),  64'hC0DE_0006);
        step();
        check("bp_c8_valid", 64'(rsp_valid), 64'd1);
        check("bp_c8_head",  64'(rsp_addr),  64'h1C);
        check("bp_c8_inst",  64'(rsp_inst),  64'hC0DE_0007);
        step();
        check("bp_c9_valid", 64'(rsp_valid), 64'd0);

        // ---------------- misaligned / out of range ----------------
        req_valid = 1'b1; req_addr = 32'h6; settle();
        check("err_mis_ready",  64'(req_ready), 64'd1);
        check("err_mis_mem_en", 64'(mem_en),    64'd0);
        step();
        req_addr = 32'h4000; settle();
        check("err_oor_ready",  64'(req_ready), 64'd1);
        check("err_oor_mem_en", 64'(mem_en),    64'd0);
        step();
        req_valid = 1'b0; settle();
        check("err_mis_valid", 64'(rsp_valid), 64'd1);
        check("err_mis_err",   64'(rsp_err),   64'd1);
        check("err_mis_inst",  64'(rsp_inst),  64'h0000_0013);
        check("err_mis_addr",  64'(rsp_addr),  64'h6);
        step();
        check("err_oor_valid", 64'(rsp_valid), 64'd1);
        check("err_oor_err",   64'(rsp_err),   64'd1);
        check("err_oor_inst",  64'(rsp_inst),  64'h0000_0013);
        check("err_oor_addr",  64'(rsp_addr),  64'h4000);
        step();
        check("err_drained", 64'(rsp_valid), 64'd0);

        // ---------------- flush ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        req_addr = 32'h100; flush = 1'b1; settle();
        check("fl_f_ready",  64'(req_ready), 64'd1);
        check("fl_f_mem_en", 64'(mem_en),    64'd1);
        step();
        flush = 1'b0; req_valid = 1'b0; settle();
        check("fl_f1_valid", 64'(rsp_valid), 64'd0);
        step();
        rsp_ready = 1'b1; settle();
        check("fl_f2_valid", 64'(rsp_valid), 64'd1);
        check("fl_f2_addr",  64'(rsp_addr),  64'h100);
        check("fl_f2_inst",  64'(rsp_inst),  64'hC0DE_0040);
        step();
        check("fl_f3_valid", 64'(rsp_valid), 64'd0);

        // ---------------- async reset mid-operation ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20;
        step();
        req_addr = 32'h24;
        step();
        req_addr = 32'h28; settle();
        check("ar_pre_valid",  64'(rsp_valid), 64'd1);
        check("ar_pre_mem_en", 64'(mem_en),    64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        check("ar_req_ready", 64'(req_ready), 64'd0);
        check("ar_mem_en",    64'(mem_en),    64'd0);
        req_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("ar_post0_valid", 64'(rsp_valid), 64'd0);
        step();
        check("ar_post1_valid", 64'(rsp_valid), 64'd0);
        req_valid = 1'b1; req_addr = 32'h8; settle();
        check("ar_new_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0; settle();
        check("ar_new_c1_valid", 64'(rsp_valid), 64'd0);
        step();
        check("ar_new_c2_valid", 64'(rsp_valid), 64'd1);
        check("ar_new_c2_addr",  64'(rsp_addr),  64'h8);
        check("ar_new_c2_inst",  64'(rsp_inst),  64'hC0DE_0002);
        step();
        check("ar_new_drained", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
